// File: rtl/bus_source_driver.sv
// bus_source_driver: registered lowest-index-wins bus source mux with sticky conflict flag and transfer/conflict counters (define BUS_IDLE_ZERO_EN to zero the bus on idle cycles)
module bus_source_driver #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 24,
  parameter int SEL_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_out,
  input  logic                          conflict_clr,
  output logic [DATA_WIDTH-1:0]         BUS_MUX_OUT,
  output logic                          bus_valid,
  output logic [SEL_WIDTH-1:0]          bus_sel,
  output logic                          conflict,
  output logic [CNT_WIDTH-1:0]          conflict_cnt,
  output logic [CNT_WIDTH-1:0]          xfer_cnt
);
  logic [NUM_SRC-1:0]    w_win;
  logic                  w_any;
  logic                  w_multi;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SEL_WIDTH-1:0]  w_sel;
  assign w_win   = src_out & (~src_out + NUM_SRC'(1));
  assign w_any   = |src_out;
  assign w_multi = |(src_out & ~w_win);
  always_comb begin
    w_data = '0;
    w_sel  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_data = w_data | (src_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_win[i]}});
      w_sel  = w_sel | (w_win[i] ? SEL_WIDTH'(i) : '0);
    end
  end
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      BUS_MUX_OUT  <= '0;
      bus_valid    <= 1'b0;
      bus_sel      <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      xfer_cnt     <= '0;
    end else begin
      bus_valid <= w_any;
      if (w_any) begin
        BUS_MUX_OUT <= w_data;
        bus_sel     <= w_sel;
        xfer_cnt    <= xfer_cnt + CNT_WIDTH'(1);
      end
`ifdef BUS_IDLE_ZERO_EN
      else begin
        BUS_MUX_OUT <= '0;
        bus_sel     <= '0;
      end
`endif
      conflict <= w_multi | (conflict & ~conflict_clr);
      if (w_multi && !(&conflict_cnt))
        conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_bus_source_driver.sv
// tb_bus_source_driver: directed and random stimulus checked against a behavioural bus model
module tb_bus_source_driver;
  localparam int DW = 32;
  localparam int NS = 24;
  localparam int SW = 5;
  localparam int CW = 16;
  logic             clock = 1'b0;
  logic             clear_n = 1'b0;
  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]    src_out = '0;
  logic             conflict_clr = 1'b0;
  logic [DW-1:0]    BUS_MUX_OUT;
  logic             bus_valid;
  logic [SW-1:0]    bus_sel;
  logic             conflict;
  logic [CW-1:0]    conflict_cnt;
  logic [CW-1:0]    xfer_cnt;
  logic [DW-1:0]    words [NS];
  logic [DW-1:0]    e_bus = '0;
  logic             e_valid = 1'b0;
  logic [SW-1:0]    e_sel = '0;
  logic             e_conf = 1'b0;
  logic [CW-1:0]    e_ccnt = '0;
  logic [CW-1:0]    e_xcnt = '0;
  int               errors = 0;
  int               checks = 0;
  bit               chk_en = 1'b1;
  always #5 clock = ~clock;
  bus_source_driver dut (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
    .conflict_clr(conflict_clr), .BUS_MUX_OUT(BUS_MUX_OUT), .bus_valid(bus_valid),
    .bus_sel(bus_sel), .conflict(conflict), .conflict_cnt(conflict_cnt), .xfer_cnt(xfer_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [NS-1:0] out, input logic clr, input logic cn);
    int n;
    int w;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = words[i];
    src_out = out;
    conflict_clr = clr;
    clear_n = cn;
    @(posedge clock);
    n = $countones(out);
    w = -1;
    for (int i = NS - 1; i >= 0; i--) if (out[i]) w = i;
    if (!cn) begin
      e_bus = '0; e_valid = 1'b0; e_sel = '0; e_conf = 1'b0; e_ccnt = '0; e_xcnt = '0;
    end else begin
      e_valid = (n > 0);
      if (n > 0) begin
        e_bus = words[w];
        e_sel = SW'(w);
        e_xcnt = e_xcnt + 1'b1;
      end else begin
`ifdef BUS_IDLE_ZERO_EN
        e_bus = '0;
        e_sel = '0;
`endif
      end
      if (n >= 2) begin
        e_conf = 1'b1;
        if (e_ccnt != 16'hFFFF) e_ccnt = e_ccnt + 1'b1;
      end else if (clr) e_conf = 1'b0;
    end
    #1;
    if (chk_en) begin
      chk("bus", BUS_MUX_OUT, e_bus);
      chk("valid", bus_valid, e_valid);
      chk("sel", bus_sel, e_sel);
      chk("conflict", conflict, e_conf);
      chk("conflict_cnt", conflict_cnt, e_ccnt);
      chk("xfer_cnt", xfer_cnt, e_xcnt);
    end
  endtask
  initial begin
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) words[i] = $urandom;
    words[3] = 32'hDEADBEEF;
    step(24'h1 << 3, 1'b0, 1'b0);
    step(24'h1 << 3, 1'b0, 1'b0);
    chk("reset_bus", BUS_MUX_OUT, 32'h0);
    step(24'h1 << 3, 1'b0, 1'b1);
    chk("release_bus", BUS_MUX_OUT, 32'hDEADBEEF);
    chk("release_xcnt", xfer_cnt, 16'd1);
    words[0] = 32'h5;
    words[20] = 32'h100;
    step(24'h1 << 0, 1'b0, 1'b1);
    chk("r0_bus", BUS_MUX_OUT, 32'h5);
    step(24'h1 << 20, 1'b0, 1'b1);
    chk("pc_sel", bus_sel, 5'd20);
    words[7] = 32'h12345678;
    step(24'h1 << 7, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
`ifndef BUS_IDLE_ZERO_EN
    chk("idle_hold", BUS_MUX_OUT, 32'h12345678);
`endif
    words[2] = 32'hA5A5A5A5;
    step((24'h1 << 5) | (24'h1 << 2), 1'b0, 1'b1);
    chk("conf_bus", BUS_MUX_OUT, 32'hA5A5A5A5);
    chk("conf_cnt", conflict_cnt, 16'd1);
    step(24'h1 << 9, 1'b1, 1'b1);
    chk("conf_cleared", conflict, 1'b0);
    step((24'h1 << 1) | (24'h1 << 23), 1'b1, 1'b1);
    chk("set_wins", conflict, 1'b1);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NS; i++) words[i] = $urandom;
      case ($urandom_range(0, 3))
        0: r = '0;
        1, 2: r = 24'h1 << $urandom_range(0, NS - 1);
        default: r = NS'($urandom);
      endcase
      step(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) != 0));
    end
    step(24'h1 << 4, 1'b0, 1'b0);
    chk_en = 1'b0;
    repeat (65535) step((24'h1 << 5) | (24'h1 << 2), 1'b0, 1'b1);
    chk_en = 1'b1;
    step((24'h1 << 5) | (24'h1 << 2), 1'b0, 1'b1);
    chk("saturate", conflict_cnt, 16'hFFFF);
    chk("wrap", xfer_cnt, 16'h0);
    step((24'h1 << 5) | (24'h1 << 2), 1'b1, 1'b1);
    step(24'h1 << 11, 1'b0, 1'b0);
    chk("mid_reset_bus", BUS_MUX_OUT, 32'h0);
    chk("mid_reset_xcnt", xfer_cnt, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
